// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer and HI/LO register owner for the
// pipelined MIPS core.
//
// An md operation issued from the E stage has its result computed on the
// start edge and held in pending registers. A down-counter then models the
// fixed unit latency, and the result is copied into HI/LO on the edge where
// the count expires. The unit also requests a D-stage stall so that no
// md-class instruction overlaps an operation in flight.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   reset    - synchronous, active-high reset
//   start    - E-stage md instruction valid this cycle
//   op       - 0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo, 6/7 no-op
//   A, B     - forwarded rs / rt operands
//   md_D     - D-stage instruction is md-class
//   busy     - operation in flight (registered)
//   HI, LO   - architectural HI/LO registers (registered)
//   stall_md - combinational D-stage stall request
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_D,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        stall_md
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;

  logic        accept_md;
  logic        finish;
  logic        is_div;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;
  logic [31:0] abs_a, abs_b, divisor, uq, ur;

  // Only an idle unit accepts a long-latency operation; a start seen while
  // busy is dropped so the pending result is never disturbed.
  assign accept_md = (state == IDLE) && start && (op <= 3'd3);
  assign is_div    = op[1];
  assign finish    = (state == RUN) && (cnt == 4'd1);
  assign busy      = (state == RUN);
  assign stall_md  = md_D & (busy | (start & (op <= 3'd3)));

  // Signed division is done on magnitudes so that 0x80000000 / -1 wraps to
  // 0x80000000 with a zero remainder instead of trapping. A zero divisor is
  // replaced by 1 only to keep the arithmetic defined; that result is never
  // written back.
  always_comb begin
    prod    = '0;
    abs_a   = A;
    abs_b   = B;
    divisor = 32'd1;
    uq      = '0;
    ur      = '0;
    res_hi  = '0;
    res_lo  = '0;
    case (op)
      3'd0: begin
        prod   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      3'd1: begin
        prod   = {32'd0, A} * {32'd0, B};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      3'd2: begin
        abs_a   = A[31] ? (~A + 32'd1) : A;
        abs_b   = B[31] ? (~B + 32'd1) : B;
        divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
        uq      = abs_a / divisor;
        ur      = abs_a % divisor;
        res_lo  = (A[31] ^ B[31]) ? (~uq + 32'd1) : uq;
        res_hi  = A[31] ? (~ur + 32'd1) : ur;
      end
      3'd3: begin
        divisor = (B == 32'd0) ? 32'd1 : B;
        res_lo  = A / divisor;
        res_hi  = A % divisor;
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

  // Next-state logic: IDLE loads the latency counter on an accepted
  // operation, RUN counts down and returns to IDLE on the expiring edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept_md) begin
          state_nxt = RUN;
          cnt_nxt   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
      end
      RUN: begin
        if (finish) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, pending result and HI/LO registers. A divide by zero still runs
  // its full latency but clears pend_wr so HI/LO keep their old values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept_md) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= !(is_div && (B == 32'd0));
      end
      if (finish && pend_wr) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end else if ((state == IDLE) && start && (op == 3'd4)) begin
        HI <= A;
      end else if ((state == IDLE) && start && (op == 3'd5)) begin
        LO <= A;
      end
    end
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide unit sequencer with HI/LO register owner for the pipelined MIPS core.
- Accepts one mult/multu/div/divu/mthi/mtlo operation from the E stage.
- Counts fixed execution latency and drives the `busy` bit carried in the stage message bundle.
- Raises a D-stage stall while any md-class instruction would collide with an operation in flight.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage md instruction valid this cycle
- op  input  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo; 6,7 are no-op
- A  input  32  rs operand (forwarded value)
- B  input  32  rt operand (forwarded value)
- md_D  input  1  instruction in D stage is md-class (mult/div/mfhi/mflo/mthi/mtlo)
- busy  output  1  operation in flight (registered)
- HI  output  32  HI register (registered)
- LO  output  32  LO register (registered)
- stall_md  output  1  combinational D-stage stall request

Behaviour:
- Reset: busy=0, HI=0, LO=0, counter=0, pending result discarded. Reset wins over start on the same edge. Reset mid-operation aborts the operation and leaves HI/LO=0.
- States: IDLE (busy=0) and RUN (busy=1), with a 4-bit down-counter.
- IDLE, start=1, op in {0..3}:
  - Compute the result from A/B as sampled at this edge and store it in pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - HI/LO stay unchanged during RUN.
- RUN: decrement the counter each edge. On the edge where the count expires, go to IDLE and copy pending into HI/LO on that same edge.
  - Net timing: start sampled at edge E0, busy=1 for exactly N cycles (after E0 up to edge EN), new HI/LO visible after EN.
- IDLE, start=1, op=4: HI<=A at the next edge. op=5: LO<=A at the next edge. busy stays 0.
- start with op 6/7: no effect.
- start while busy=1 is a protocol violation the stall prevents. If it occurs anyway it is ignored: no restart, pending result preserved.
- mult: signed 32x32 to 64-bit product, HI=[63:32], LO=[31:0]. multu: unsigned.
- div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (B=0, div or divu): the operation still runs DIV_CYCLES with busy asserted, and HI/LO are left unchanged at completion.
- stall_md = md_D & (busy | (start & op<=3)). The stall covers the start cycle, so a following mfhi/mflo never reads stale data.
- The last RUN cycle still stalls; stall_md drops in the first cycle where busy=0.
- HI/LO are outputs only; mfhi/mflo select them downstream, with no read bypass of the pending result.

Test Plan:
- Reset then idle: assert reset 2 cycles -> busy=0, HI=0, LO=0, stall_md=0 with md_D=1, start=0.
- Signed mult: start op=0, A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles, HI/LO unchanged during those cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu of the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- Signed div: A=0xFFFFFFF9 (-7), B=2, op=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Overflow and zero divide:
  - div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
  - With HI=0x11, LO=0x22, divu B=0 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
- Stall/ignore: md_D=1 held from start cycle -> stall_md=1 on start cycle plus all 5 busy cycles, 0 after. Second start (op=1) pulsed mid-run -> ignored, first result lands on schedule.
- mthi/mtlo and reset abort:
  - op=4 A=0xDEADBEEF -> HI=0xDEADBEEF next edge, busy never asserts.
  - Reset at cycle 3 of a div -> busy=0, HI=LO=0, no later write.
